// File: rtl/spike_train_encoder.sv
// spike_train_encoder
//
// Rate encoder that turns one signed accumulated spike count into a spike train.
// It accepts a count over a valid/ready handshake and clamps it to [0, WINDOW].
// Over the next WINDOW timestep strobes it emits exactly that many spikes,
// spread evenly by a phase accumulator (Bresenham-style).
//
// Ports:
//   clk           in   clock, rising edge
//   rstn          in   synchronous reset, active-high (name kept for codebase consistency)
//   in_count      in   signed count to encode (DATA_WIDTH bits)
//   in_valid      in   in_count is valid
//   in_ready      out  encoder can take a new count (IDLE only)
//   step          in   one-cycle timestep strobe
//   spike         out  registered spike, one cycle per emitted spike
//   window_active out  high while a window is running
//   window_done   out  one-cycle pulse after the last timestep of a window
//   spike_count   out  spikes emitted in the current or last window (zero-extended)

module spike_train_encoder #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned WINDOW     = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [DATA_WIDTH-1:0] in_count,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  step,
    output logic                  spike,
    output logic                  window_active,
    output logic                  window_done,
    output logic [DATA_WIDTH-1:0] spike_count
);

    // Phase and target both hold values up to WINDOW; the step counter only
    // has to reach WINDOW-1.
    localparam int unsigned PW = $clog2(WINDOW) + 1;
    localparam int unsigned SW = $clog2(WINDOW);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [PW:0]                  WIN_SUM   = (PW + 1)'(WINDOW);
    localparam logic [PW-1:0]                WIN_TGT   = PW'(WINDOW);
    localparam logic signed [DATA_WIDTH-1:0] WIN_S     = DATA_WIDTH'(WINDOW);
    localparam logic [SW-1:0]                LAST_STEP = SW'(WINDOW - 1);

    logic [1:0]            state_q, state_d;
    logic [PW-1:0]         phase_q, phase_d;
    logic [PW-1:0]         target_q, target_d;
    logic [SW-1:0]         step_cnt_q, step_cnt_d;
    logic [DATA_WIDTH-1:0] spike_count_q, spike_count_d;
    logic                  spike_q, spike_d;

    logic signed [DATA_WIDTH-1:0] count_s;
    logic [PW-1:0]                target_clamped;
    logic [PW:0]                  sum;
    logic                         fire;

    assign count_s = $signed(in_count);

    // Signed clamp to [0, WINDOW]; once past both compares the value fits in PW bits.
    always_comb begin
        target_clamped = '0;
        if (count_s < 0) begin
            target_clamped = '0;
        end else if (count_s > WIN_S) begin
            target_clamped = WIN_TGT;
        end else begin
            target_clamped = in_count[PW-1:0];
        end
    end

    // phase < WINDOW and target <= WINDOW, so the one-bit-wider sum never wraps.
    assign sum  = {1'b0, phase_q} + {1'b0, target_q};
    assign fire = (sum >= WIN_SUM);

    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        target_d      = target_q;
        step_cnt_d    = step_cnt_q;
        spike_count_d = spike_count_q;
        spike_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    target_d      = target_clamped;
                    phase_d       = '0;
                    step_cnt_d    = '0;
                    spike_count_d = '0;
                    state_d       = RUN;
                end
            end
            RUN: begin
                if (step) begin
                    if (fire) begin
                        spike_d       = 1'b1;
                        phase_d       = PW'(sum - WIN_SUM);
                        spike_count_d = spike_count_q + 1'b1;
                    end else begin
                        phase_d = PW'(sum);
                    end
                    step_cnt_d = step_cnt_q + 1'b1;
                    if (step_cnt_q == LAST_STEP) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                // Single-cycle completion marker; a step here is dropped.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q       <= IDLE;
            phase_q       <= '0;
            target_q      <= '0;
            step_cnt_q    <= '0;
            spike_count_q <= '0;
            spike_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            target_q      <= target_d;
            step_cnt_q    <= step_cnt_d;
            spike_count_q <= spike_count_d;
            spike_q       <= spike_d;
        end
    end

    // Status outputs decode registered state, so they are glitch-free.
    assign in_ready      = (state_q == IDLE);
    assign window_active = (state_q == RUN);
    assign window_done   = (state_q == DONE);
    assign spike         = spike_q;
    assign spike_count   = spike_count_q;

endmodule

// File: doc/spike_train_encoder.md
Name: spike_train_encoder

Overview:
Rate encoder that turns an accumulated spike count back into a spike train. It is the inverse of the threshold/accumulator activation path: one signed count is accepted over a valid/ready handshake. Across a window of WINDOW timesteps, exactly clamp(count, 0, WINDOW) spikes are emitted, spread evenly. It feeds spikes into the next layer's neuron inputs.

Parameters:
DATA_WIDTH, 16, width of the signed input count and of the emitted-spike counter.
WINDOW, 16, timesteps per encoding window. Legal range is 2 to 2^(DATA_WIDTH-1)-1.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rstn  input  1  reset, synchronous, active-high (1 = reset; the name is kept for codebase consistency).
in_count  input  DATA_WIDTH  signed accumulated spike count to encode.
in_valid  input  1  in_count is valid.
in_ready  output  1  encoder can accept a new count (high only in IDLE).
step  input  1  one-cycle timestep strobe; advances the window by one timestep.
spike  output  1  registered spike; high for exactly one cycle per emitted spike.
window_active  output  1  high while in RUN.
window_done  output  1  one-cycle pulse when the window finishes.
spike_count  output  DATA_WIDTH  spikes emitted in the current or last window (unsigned value, zero-extended).

Behaviour:
- Reset (rstn=1 at a clock edge):
  - state <= IDLE.
  - spike, window_done, window_active, spike_count, phase, step_cnt and target all <= 0.
  - in_ready = 1 from the first cycle after reset.
  - Reset wins over every other input in the same cycle.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1; step is ignored.
  - On in_valid & in_ready:
    - target <= clamp(in_count, 0, WINDOW), i.e. negative -> 0 and > WINDOW -> WINDOW.
    - phase <= 0; step_cnt <= 0; spike_count <= 0.
    - Go to RUN.
- RUN:
  - in_ready = 0; in_valid is ignored (not queued).
  - On step=1:
    - p = phase + target.
    - If p >= WINDOW: spike <= 1, phase <= p - WINDOW, spike_count <= spike_count + 1.
    - Else: spike <= 0, phase <= p.
    - step_cnt <= step_cnt + 1.
    - If step_cnt == WINDOW-1, go to DONE.
  - On step=0: spike <= 0 and all other state holds. Steps may be separated by arbitrary gaps.
- DONE:
  - Lasts exactly one cycle; window_done = 1; then go to IDLE.
  - spike_count holds its final value until the next accept.
  - A step in DONE is ignored.
- Latency:
  - spike rises the cycle after the step edge that produced it.
  - window_done is high the cycle after the WINDOW-th step is sampled.
  - in_ready returns 1 the cycle after that.
- Invariants:
  - After k accepted steps, spike_count = floor(k*target/WINDOW).
  - At window end, spike_count == target exactly.
  - No two spikes come from a single step.
- Widths:
  - phase needs clog2(WINDOW)+1 bits; the sum p is computed one bit wider, so no overflow.
  - step_cnt needs clog2(WINDOW) bits.
  - The clamp compare is signed.
- Reset mid-RUN: abandon the window; no window_done pulse; return to the reset state.

Test Plan:
- Reset → hold rstn=1 for 3 cycles with in_valid=1 and step=1 → spike=0, window_done=0, spike_count=0, in_ready=1 after release, nothing accepted while rstn=1.
- Even spacing → WINDOW=16, in_count=4, 16 step pulses spaced 3 cycles apart → spikes on steps 4, 8, 12, 16 only; spike_count=4; a single window_done pulse one cycle after step 16; in_ready=1 the cycle after that.
- Full rate and clamp → in_count=16 gives a spike on every step, spike_count=16. in_count=100 behaves identically. Back-to-back steps (step held high 16 cycles) give 16 consecutive spike cycles.
- Negative and zero → in_count=-5, then in_count=0 → no spikes in either window, spike_count=0, window_done pulses after the 16th step each time.
- Handshake → in_valid=1 with in_count=8 held through RUN → accepted once only (in_ready=0 in RUN), 8 spikes. The held value is re-accepted in IDLE after DONE. step pulses in IDLE produce no spikes.
- Mid-window reset → in_count=8, 5 steps, then rstn=1 for 1 cycle → spike_count=0, state IDLE, no window_done. A new in_count=2 then yields spikes on steps 8 and 16.
